// File: rtl/scope_ui_pkg.sv
// Shared types and defaults for the scope mouse UI: FSM states, region width, step sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a. The display overlay that draws the region labels uses the same defaults.
package scope_ui_pkg;

  typedef enum logic [1:0] {
    UI_IDLE       = 2'd0,
    UI_HOLD_FIRST = 2'd1,
    UI_REPEAT     = 2'd2
  } ui_state_t;

  // Horizontal pixels per adjustable setting on screen.
  localparam int UI_REGION_W_DEF    = 300;
  // Accumulator LSBs per step (accumulator carries fractional bits below the value).
  localparam int UI_FINE_STEP_DEF   = 1;
  localparam int UI_COARSE_STEP_DEF = 10;

endpackage

// File: rtl/ui_sat_accum.sv
// One saturating fixed-point setting accumulator with a change strobe on its integer part.
// Latency: step request at cycle t updates value/changed at t+1.
// Backpressure: none; a step is accepted every cycle step_en is high.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (acc returns to INIT_VAL)
//   step_en        apply one step this cycle
//   step_dn        1 = subtract step_size, 0 = add
//   step_size      step magnitude in accumulator LSBs
//   value          integer part of the accumulator, straight from the register
//   changed        one-cycle strobe when the last step altered value
module ui_sat_accum #(
  parameter int               VAL_W    = 12,
  parameter int               FRAC_W   = 7,
  parameter logic [VAL_W-1:0] INIT_VAL = '0,
  parameter int               MIN_VAL  = 1,
  parameter int               MAX_VAL  = 2047
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_en,
  input  logic                    step_dn,
  input  logic [VAL_W+FRAC_W-1:0] step_size,
  output logic [VAL_W-1:0]        value,
  output logic                    changed
);

  localparam int ACC_W = VAL_W + FRAC_W;
  // Two headroom bits: one for the sign on underflow, one so that an
  // accumulator already near full scale cannot overflow before the clamp.
  localparam int SUM_W = ACC_W + 2;

  localparam longint LO_L = longint'(MIN_VAL) << FRAC_W;
  localparam longint HI_L = (longint'(MAX_VAL) << FRAC_W) | ((longint'(1) << FRAC_W) - 1);
  localparam logic signed [SUM_W-1:0] LO = LO_L[SUM_W-1:0];
  localparam logic signed [SUM_W-1:0] HI = HI_L[SUM_W-1:0];

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    changed_q, changed_d;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] clamped;

  always_comb begin
    sum     = '0;
    clamped = '0;
    acc_d   = acc_q;
    changed_d = 1'b0;
    if (step_dn) begin
      sum = $signed({2'b00, acc_q}) - $signed({2'b00, step_size});
    end else begin
      sum = $signed({2'b00, acc_q}) + $signed({2'b00, step_size});
    end
    if (sum < LO) begin
      clamped = LO;
    end else if (sum > HI) begin
      clamped = HI;
    end else begin
      clamped = sum;
    end
    if (step_en) begin
      acc_d = clamped[ACC_W-1:0];
      // Only integer-part movement is visible downstream; fractional-only
      // steps and steps swallowed by the clamp stay silent.
      changed_d = (clamped[ACC_W-1:FRAC_W] != acc_q[ACC_W-1:FRAC_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= {INIT_VAL, {FRAC_W{1'b0}}};
      changed_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      changed_q <= changed_d;
    end
  end

  assign value   = acc_q[ACC_W-1:FRAC_W];
  assign changed = changed_q;

endmodule

// File: rtl/ui_param_ctrl.sv
// Mouse-driven bank of NUM_CH scope settings with hold-to-repeat, acceleration and saturation.
// Latency: a step decided at cycle t shows on values/changed at t+1.
// Backpressure: none; buttons are levels, sampled every cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   left/right/middle_mouse   decrement / increment / coarse-step levels
//   xpos                      cursor x; selects channel xpos / REGION_W at press time
//   values                    packed settings, channel i in [i*VAL_W +: VAL_W]
//   changed                   per-channel one-cycle strobe on value change
//   active_ch                 locked channel while busy, NUM_CH otherwise
//   busy                      high while a press is being held (not IDLE)
module ui_param_ctrl
  import scope_ui_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      VAL_W       = 12,
  parameter int                      FRAC_W      = 7,
  parameter int                      X_W         = 12,
  parameter int                      REGION_W    = UI_REGION_W_DEF,
  parameter logic [NUM_CH*VAL_W-1:0] INIT_VALS   = {12'd16, 12'd127, 12'd3},
  parameter int                      MIN_VAL     = 1,
  parameter int                      MAX_VAL     = 2047,
  parameter int                      FINE_STEP   = UI_FINE_STEP_DEF,
  parameter int                      COARSE_STEP = UI_COARSE_STEP_DEF,
  parameter int                      HOLD_FIRST  = 100000,
  parameter int                      HOLD_REPEAT = 25000,
  parameter int                      ACCEL_N     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           left_mouse,
  input  logic                           right_mouse,
  input  logic                           middle_mouse,
  input  logic [X_W-1:0]                 xpos,
  output logic [NUM_CH*VAL_W-1:0]        values,
  output logic [NUM_CH-1:0]              changed,
  output logic [$clog2(NUM_CH+1)-1:0]    active_ch,
  output logic                           busy
);

  localparam int CH_W    = $clog2(NUM_CH + 1);
  localparam int ACC_W   = VAL_W + FRAC_W;
  localparam int TMR_MAX = (HOLD_FIRST > HOLD_REPEAT) ? HOLD_FIRST : HOLD_REPEAT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RPT_W   = $clog2(ACCEL_N + 1);

  localparam logic [CH_W-1:0]  CH_NONE  = CH_W'(NUM_CH);
  localparam logic [TMR_W-1:0] HF_LAST  = TMR_W'(HOLD_FIRST - 1);
  localparam logic [TMR_W-1:0] HR_LAST  = TMR_W'(HOLD_REPEAT - 1);
  localparam logic [RPT_W-1:0] RPT_SAT  = RPT_W'(ACCEL_N);

  ui_state_t         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              dn_q, dn_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;

  logic              req_up, req_dn, held_same;
  logic [CH_W-1:0]   xch;
  logic              step_en, step_dn, accel;
  logic [CH_W-1:0]   step_ch;
  logic [ACC_W-1:0]  step_size;

  // Both buttons together cancel out, same as neither.
  assign req_up    = right_mouse & ~left_mouse;
  assign req_dn    = left_mouse & ~right_mouse;
  assign held_same = dn_q ? req_dn : req_up;

  // Region decode by range compare instead of a divider; lowest matching
  // region wins, anything past the last region decodes to CH_NONE.
  always_comb begin
    xch = CH_NONE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (int'(xpos) < (i + 1) * REGION_W) begin
        xch = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dn_d    = dn_q;
    tmr_d   = tmr_q;
    rpt_d   = rpt_q;
    step_en = 1'b0;
    step_ch = ch_q;
    step_dn = dn_q;
    case (state_q)
      UI_IDLE: begin
        if ((req_up || req_dn) && (xch != CH_NONE)) begin
          step_en = 1'b1;
          step_ch = xch;
          step_dn = req_dn;
          ch_d    = xch;
          dn_d    = req_dn;
          tmr_d   = '0;
          rpt_d   = '0;
          state_d = UI_HOLD_FIRST;
        end
      end
      UI_HOLD_FIRST, UI_REPEAT: begin
        if (!held_same) begin
          state_d = UI_IDLE;
        end else if (tmr_q == ((state_q == UI_HOLD_FIRST) ? HF_LAST : HR_LAST)) begin
          // Every step after the press counts as a repeat, including the
          // first one that leaves HOLD_FIRST.
          step_en = 1'b1;
          tmr_d   = '0;
          state_d = UI_REPEAT;
          if (rpt_q != RPT_SAT) begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = UI_IDLE;
      end
    endcase
  end

  // rpt_q is stale in IDLE, so the press step never uses acceleration.
  assign accel     = (state_q != UI_IDLE) && (rpt_q >= RPT_SAT);
  assign step_size = (middle_mouse || accel) ? ACC_W'(COARSE_STEP) : ACC_W'(FINE_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UI_IDLE;
      ch_q    <= '0;
      dn_q    <= 1'b0;
      tmr_q   <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dn_q    <= dn_d;
      tmr_q   <= tmr_d;
      rpt_q   <= rpt_d;
    end
  end

  assign busy      = (state_q != UI_IDLE);
  assign active_ch = busy ? ch_q : CH_NONE;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ui_sat_accum #(
      .VAL_W    (VAL_W),
      .FRAC_W   (FRAC_W),
      .INIT_VAL (INIT_VALS[g*VAL_W +: VAL_W]),
      .MIN_VAL  (MIN_VAL),
      .MAX_VAL  (MAX_VAL)
    ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .step_en   (step_en && (step_ch == CH_W'(g))),
      .step_dn   (step_dn),
      .step_size (step_size),
      .value     (values[g*VAL_W +: VAL_W]),
      .changed   (changed[g])
    );
  end

endmodule
